mem_request_unit: RTL
=====================

# mem_request_unit

Parametrised multi-channel memory request unit for the pipelined datapath, replacing the fixed single-cycle request unit. Each of NCH channels (channel 0 = instruction fetch, channel 1 = data, further channels for extra requesters) latches a one-cycle read/write request from the pipeline. It holds the corresponding memory enable until the cache returns a hit. Adds back-to-back request acceptance, per-channel wait-cycle timeout detection, and a halt sequence that optionally drains pending writes before reporting halted.

## Interface
Parameters:
- NCH, 2, number of independent request channels (≥1)
- WAIT_W, 8, width of per-channel wait counter; timeout threshold is 2^WAIT_W−1
- HALT_DRAIN, 1, 1 = pending writes complete before halted; 0 = all pending requests abort on halt

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- rreq  in  NCH  per-channel read request, sampled each cycle
- wreq  in  NCH  per-channel write request, sampled each cycle
- hit  in  NCH  per-channel cache hit / transaction complete
- halt  in  1  halt from writeback stage, level, sampled each cycle
- ren  out  NCH  per-channel read enable to cache
- wen  out  NCH  per-channel write enable to cache
- busy  out  NCH  channel has a request outstanding (ren|wen)
- timeout  out  NCH  channel has waited 2^WAIT_W−1 cycles without hit
- halted  out  1  all channels idle after halt; sticky

## Operation
- Per-channel FSM states: IDLE, RD, WR.
- IDLE: wreq → WR; else rreq → RD; else stay. Write has priority over read when both are set.
- RD/WR: stay until hit. On hit, go to IDLE, or directly to WR/RD if wreq/rreq is set in the same cycle (back-to-back, same priority rule).
- ren = (state==RD), wen = (state==WR), busy = ren|wen; all from registered state, no combinational path from inputs.
- rreq/wreq while in RD/WR without hit are ignored. The pipeline holds its request until it sees the channel idle or accepted.
- Wait counter, WAIT_W bits, unsigned:
  - Cleared on entry to RD/WR and in IDLE.
  - Increments each cycle in RD/WR without hit.
  - Saturates at 2^WAIT_W−1, no wrap.
  - timeout = (counter == 2^WAIT_W−1), held until hit, abort or RST.
- Halt: global halt flag is set when halt is sampled high and remains set until RST.
  - Once the flag is set, new requests are ignored in all channels.
  - In RD: abort to IDLE on the next edge.
  - In WR: continue until hit if HALT_DRAIN=1, else abort to IDLE.
  - halted asserts the cycle after the halt flag is set and all channels are IDLE. It then stays high until RST.
- Simultaneous halt and hit in WR: the channel returns to IDLE and does not accept a new request.
- Simultaneous halt and request in IDLE: the request is dropped.
- Reset values: every state IDLE, counters 0, ren=wen=busy=timeout=0, halt flag 0, halted=0. RST during any transaction drops enables on the next edge and has priority over all inputs.

## Timing
- Request sampled at edge t: ren/wen high from t+1.
- Hit sampled at edge t: enable low from t+1; if a new request is sampled at t, the new enable is high from t+1 (no idle bubble).
- Timeout: first asserted at the edge 2^WAIT_W−1 cycles after enable rises with no hit. For WAIT_W=8 this is the 255th cycle of waiting.
- Halt sampled at t with all channels idle: halted=1 from t+2 (flag at t+1, halted at t+2).
- With HALT_DRAIN=1 and a write pending: halted goes high 1 cycle after the write's hit is registered (hit at t → halted at t+2).

## Structure
- Shared package mem_req_pkg:
  - typedef enum logic [1:0] {IDLE, RD, WR} req_state_t
  - default constants for NCH and WAIT_W
- Sub-module req_chan: one channel's FSM plus saturating wait counter. Inputs are the channel's request/hit bits and the global halt flag; outputs are ren/wen/busy/timeout.
- Top module generates NCH req_chan instances. It owns the halt flag and the halted logic (AND of all instances' idle status).
- Interface mem_request_unit_if with modports ru and tb, parametrised by NCH.

## Test plan
- Reset then single read on channel 1: rreq[1]=1 for 1 cycle at t → ren[1]=1 at t+1. hit[1] at t+3 → ren[1]=0 at t+4, busy[1] tracks ren[1], channel 0 untouched.
- Back-to-back and priority: ch0 in RD, hit[0] with rreq[0]=wreq[0]=1 same cycle → next cycle wen[0]=1, ren[0]=0, no idle cycle.
- Timeout with WAIT_W=3: read with no hit → timeout=1 on the 7th waiting cycle and stays set. hit → timeout=0 and ren=0 next cycle.
- Halt drain, HALT_DRAIN=1, ch0 RD and ch1 WR pending:
  - halt at t → ren[0]=0 at t+1, wen[1] stays 1, halted=0.
  - hit[1] at t+4 → halted=1 at t+6.
  - A later rreq is ignored.
- Halt abort, HALT_DRAIN=0, same setup: both enables low at t+1, halted=1 at t+2.
- Reset mid-transaction: RST=1 while wen[0]=1 and counter at 5 → next cycle all outputs 0. After RST drops, a fresh rreq[0] is accepted normally and halted=0.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and default sizing for the memory request unit.
package mem_req_pkg;

  // Per-channel request state: idle, read outstanding, write outstanding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } req_state_t;

  localparam int NCH_DEF    = 2;
  localparam int WAIT_W_DEF = 8;

endpackage

// File: rtl/mem_request_unit_if.sv
// Bundle of the request unit's pins, with one view for the unit and one
// for whatever drives it.
interface mem_request_unit_if #(
  parameter int NCH = 2
) (
  input logic CLK
);

  logic           RST;
  logic [NCH-1:0] rreq;
  logic [NCH-1:0] wreq;
  logic [NCH-1:0] hit;
  logic           halt;
  logic [NCH-1:0] ren;
  logic [NCH-1:0] wen;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] timeout;
  logic           halted;

  modport ru (
    input  CLK, RST, rreq, wreq, hit, halt,
    output ren, wen, busy, timeout, halted
  );

  modport tb (
    input  CLK, ren, wen, busy, timeout, halted,
    output RST, rreq, wreq, hit, halt
  );

endinterface

// File: rtl/req_chan.sv
// One request channel: holds a read or write enable until the cache hits,
// accepts a follow-on request on the hit cycle, and counts wait cycles
// with saturation to flag a timeout.
module req_chan
  import mem_req_pkg::*;
#(
  parameter int WAIT_W     = WAIT_W_DEF,
  parameter int HALT_DRAIN = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rreq,
  input  logic       wreq,
  input  logic       hit,
  input  logic       halt_any,   // halt input or the latched halt flag
  output logic       ren,
  output logic       wen,
  output logic       busy,
  output logic       timeout,
  output logic       idle,
  output logic [1:0] dbg_state
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  req_state_t        state_q, state_d;
  req_state_t        req_pick;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Request the pipeline is presenting this cycle; write wins over read.
  always_comb begin
    req_pick = IDLE;
    if (wreq)      req_pick = WR;
    else if (rreq) req_pick = RD;
  end

  // Next state and wait counter. A hit always ends the current wait, so the
  // counter restarts from zero even when the same op is accepted back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (!halt_any) state_d = req_pick;
      end
      RD: begin
        if (halt_any)  state_d = IDLE;
        else if (hit)  state_d = req_pick;
      end
      WR: begin
        if (halt_any && (HALT_DRAIN == 0)) state_d = IDLE;
        else if (hit)                      state_d = halt_any ? IDLE : req_pick;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && (state_d == state_q) && !hit) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WAIT_W'(1);
    end
  end

  // State and counter registers; reset overrides every input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ren       = (state_q == RD);
  assign wen       = (state_q == WR);
  assign busy      = ren | wen;
  assign idle      = (state_q == IDLE);
  assign timeout   = (cnt_q == CNT_MAX);
  assign dbg_state = state_q;

endmodule

// File: rtl/mem_request_unit.sv
// Multi-channel memory request unit: NCH independent request channels
// sharing a sticky halt flag and a sticky halted indication.
module mem_request_unit
  import mem_req_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int WAIT_W     = WAIT_W_DEF,
  parameter int HALT_DRAIN = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] rreq,
  input  logic [NCH-1:0] wreq,
  input  logic [NCH-1:0] hit,
  input  logic           halt,
  output logic [NCH-1:0] ren,
  output logic [NCH-1:0] wen,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] timeout,
  output logic           halted
);

  logic           halt_q;
  logic           halted_q;
  logic           halt_any;
  logic [NCH-1:0] idle;
  logic [1:0]     dbg_state [NCH];

  // A halt seen this cycle already blocks new requests and aborts reads.
  assign halt_any = halt | halt_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    req_chan #(
      .WAIT_W     (WAIT_W),
      .HALT_DRAIN (HALT_DRAIN)
    ) u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .rreq      (rreq[i]),
      .wreq      (wreq[i]),
      .hit       (hit[i]),
      .halt_any  (halt_any),
      .ren       (ren[i]),
      .wen       (wen[i]),
      .busy      (busy[i]),
      .timeout   (timeout[i]),
      .idle      (idle[i]),
      .dbg_state (dbg_state[i])
    );
  end

  // Sticky halt flag, and halted once the flag is up with every channel idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      halt_q   <= halt_q | halt;
      halted_q <= halted_q | (halt_q & (&idle));
    end
  end

  assign halted = halted_q;

endmodule
